// File: rtl/onehot_exp_accumulator.sv
// Signed one-hot histogram of exponent sums. Each beat carries LANES terms,
// each term naming a bin and a sign. Per-bin signed counters saturate
// instead of wrapping. A beat flagged last hands the completed group to a
// one-entry output register with a valid/ready handshake.
module onehot_exp_accumulator #(
  parameter int EXP_W = 4,
  parameter int LANES = 2,
  parameter int CNT_W = 8,
  localparam int NBIN = 2 ** EXP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*EXP_W-1:0]  in_exp,
  input  logic [LANES-1:0]        in_sign,
  input  logic [LANES-1:0]        in_en,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NBIN*CNT_W-1:0]   out_bins,
  output logic                    out_sat
);

  // A per-beat contribution spans [-LANES, +LANES].
  // The sum width leaves headroom so an unclamped sum never overflows.
  localparam int CW = $clog2(LANES + 1) + 1;
  localparam int SW = CNT_W + CW;
  localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (CNT_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic signed [CNT_W-1:0]   r_acc [NBIN];
  logic                      r_flag;
  logic [NBIN*CNT_W-1:0]     r_outBins;
  logic                      r_outSat;

  logic signed [CW-1:0]      w_contrib [NBIN];
  logic signed [SW-1:0]      w_sum [NBIN];
  logic signed [CNT_W-1:0]   w_satSum [NBIN];
  logic                      w_beatSat;
  logic                      w_accept;
  logic                      w_lastAccept;

  assign out_valid    = (r_state == FULL);
  assign in_ready     = !out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_lastAccept = w_accept && in_last;
  assign out_bins     = r_outBins;
  assign out_sat      = r_outSat;

  // Decode lanes into per-bin signed contributions.
  // Add each contribution to its counter and clamp the result to the counter range.
  always_comb begin
    w_beatSat = 1'b0;
    for (int b = 0; b < NBIN; b++) begin
      w_contrib[b] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (in_en[l] && (in_exp[l*EXP_W +: EXP_W] == EXP_W'(b))) begin
          if (in_sign[l]) w_contrib[b] = w_contrib[b] - CW'(1);
          else            w_contrib[b] = w_contrib[b] + CW'(1);
        end
      end
      w_sum[b] = SW'(r_acc[b]) + SW'(w_contrib[b]);
      if (w_sum[b] > MAXV) begin
        w_satSum[b] = MAXV[CNT_W-1:0];
        w_beatSat   = 1'b1;
      end else if (w_sum[b] < MINV) begin
        w_satSum[b] = MINV[CNT_W-1:0];
        w_beatSat   = 1'b1;
      end else begin
        w_satSum[b] = w_sum[b][CNT_W-1:0];
      end
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_nextState;
  end

  // Output stage next state.
  // A new last beat keeps the stage FULL; a lone consume empties it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY:   if (w_lastAccept) w_nextState = FULL;
      FULL:    if (w_lastAccept) w_nextState = FULL;
               else if (out_ready) w_nextState = EMPTY;
      default: w_nextState = EMPTY;
    endcase
  end

  // Accumulators, saturation flag and result register.
  // These update only on accepted beats; a last beat moves the group into the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBIN; b++) r_acc[b] <= '0;
      r_flag    <= 1'b0;
      r_outBins <= '0;
      r_outSat  <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        for (int b = 0; b < NBIN; b++) begin
          r_outBins[b*CNT_W +: CNT_W] <= w_satSum[b];
          r_acc[b]                    <= '0;
        end
        r_outSat <= r_flag | w_beatSat;
        r_flag   <= 1'b0;
      end else begin
        for (int b = 0; b < NBIN; b++) r_acc[b] <= w_satSum[b];
        r_flag <= r_flag | w_beatSat;
      end
    end
  end

endmodule

// File: tb/tb_onehot_exp_accumulator.sv
// Self-checking bench for onehot_exp_accumulator (LANES=2, EXP_W=4, CNT_W=8).
// Expected values come from an integer histogram model that clamps counts to the 8-bit range.
module tb_onehot_exp_accumulator;

  localparam int EXP_W = 4;
  localparam int LANES = 2;
  localparam int CNT_W = 8;
  localparam int NBIN  = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*EXP_W-1:0]  in_exp;
  logic [LANES-1:0]        in_sign;
  logic [LANES-1:0]        in_en;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [NBIN*CNT_W-1:0]   out_bins;
  logic                    out_sat;

  int nTests = 0;
  int nFail  = 0;

  // Reference model state, kept as plain integers.
  int   mAcc [NBIN];
  int   mBins [NBIN];
  bit   mFlag;
  bit   mSat;
  bit   mValid;
  logic expReady;
  logic obsReady;

  onehot_exp_accumulator #(.EXP_W(EXP_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_sign(in_sign), .in_en(in_en), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bins(out_bins), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NBIN*CNT_W-1:0] packBins();
    logic [NBIN*CNT_W-1:0] v;
    v = '0;
    for (int b = 0; b < NBIN; b++) v[b*CNT_W +: CNT_W] = CNT_W'(mBins[b]);
    return v;
  endfunction

  task automatic modelReset();
    for (int b = 0; b < NBIN; b++) begin
      mAcc[b]  = 0;
      mBins[b] = 0;
    end
    mFlag  = 0;
    mSat   = 0;
    mValid = 0;
  endtask

  // Histogram update for one accepted beat.
  task automatic modelBeat(input logic [3:0] e0, input logic [3:0] e1,
                           input logic [1:0] s, input logic [1:0] en, input logic last);
    int raw [NBIN];
    for (int b = 0; b < NBIN; b++) raw[b] = mAcc[b];
    if (en[0]) raw[e0] += (s[0] ? -1 : 1);
    if (en[1]) raw[e1] += (s[1] ? -1 : 1);
    for (int b = 0; b < NBIN; b++) begin
      if (raw[b] > 127)  begin raw[b] = 127;  mFlag = 1; end
      if (raw[b] < -128) begin raw[b] = -128; mFlag = 1; end
    end
    if (last) begin
      for (int b = 0; b < NBIN; b++) begin
        mBins[b] = raw[b];
        mAcc[b]  = 0;
      end
      mSat  = mFlag;
      mFlag = 0;
    end else begin
      for (int b = 0; b < NBIN; b++) mAcc[b] = raw[b];
    end
  endtask

  // Drive one cycle from just after a falling edge and update the model at the rising edge.
  // The cycle returns on the next falling edge. No comparisons are made here.
  task automatic applyStimulus(input logic v, input logic [3:0] e0, input logic [3:0] e1,
                               input logic [1:0] s, input logic [1:0] en,
                               input logic last, input logic ordy);
    bit acc;
    in_valid  = v;
    in_exp    = {e1, e0};
    in_sign   = s;
    in_en     = en;
    in_last   = last;
    out_ready = ordy;
    #1;
    expReady = !mValid || ordy;
    obsReady = in_ready;
    acc      = v && expReady;
    @(posedge clk);
    if (acc) modelBeat(e0, e1, s, en, last);
    if (acc && last)          mValid = 1;
    else if (mValid && ordy)  mValid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1, 4'd6, 4'd6, 2'b00, 2'b11, 1, 0);
    applyStimulus(1, 4'd8, 4'd2, 2'b01, 2'b11, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    nTests++;
    if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    nTests++;
    if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
    nTests++;
    if (out_bins !== '0) begin nFail++; $display("[TB] FAIL reset_bins got %h want 0", out_bins); end
    nTests++;
    if (out_sat !== 1'b0) begin nFail++; $display("[TB] FAIL reset_sat got %b want 0", out_sat); end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    applyStimulus(1, 4'd3, 4'd5, 2'b10, 2'b11, 1, 1);
    nTests++;
    if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL single_valid got %b want 1", out_valid); end
    nTests++;
    if (out_bins[3*8 +: 8] !== 8'h01 || out_bins[5*8 +: 8] !== 8'hFF)
      begin nFail++; $display("[TB] FAIL single_bins3_5 got %h %h want 01 ff", out_bins[3*8 +: 8], out_bins[5*8 +: 8]); end
    nTests++;
    if (out_bins !== packBins()) begin nFail++; $display("[TB] FAIL single_bins got %h want %h", out_bins, packBins()); end
    nTests++;
    if (out_sat !== 1'b0) begin nFail++; $display("[TB] FAIL single_sat got %b want 0", out_sat); end
    applyStimulus(0, 4'd0, 4'd0, 2'b00, 2'b00, 0, 1);
    nTests++;
    if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL single_consume got %b want 0", out_valid); end
  endtask

  task automatic test_groups();
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'd7, 4'd7, 2'b00, 2'b11, (i == 2), 1);
    nTests++;
    if (out_valid !== 1'b1 || out_bins[7*8 +: 8] !== 8'd6)
      begin nFail++; $display("[TB] FAIL group_bin7 got v=%b %h want v=1 06", out_valid, out_bins[7*8 +: 8]); end
    applyStimulus(1, 4'd2, 4'd2, 2'b10, 2'b11, 1, 1);
    nTests++;
    if (out_bins !== packBins() || out_bins[2*8 +: 8] !== 8'd0)
      begin nFail++; $display("[TB] FAIL group_bin2 got %h want %h", out_bins, packBins()); end
    applyStimulus(1, 4'd9, 4'd1, 2'b00, 2'b00, 1, 1);
    nTests++;
    if (out_valid !== 1'b1 || out_bins !== '0)
      begin nFail++; $display("[TB] FAIL empty_group got v=%b %h want v=1 0", out_valid, out_bins); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 70; i++) applyStimulus(1, 4'd0, 4'd0, 2'b00, 2'b11, (i == 69), 1);
    nTests++;
    if (out_bins[7:0] !== 8'h7F) begin nFail++; $display("[TB] FAIL sat_bin0 got %h want 7f", out_bins[7:0]); end
    nTests++;
    if (out_sat !== 1'b1) begin nFail++; $display("[TB] FAIL sat_flag got %b want 1", out_sat); end
    applyStimulus(1, 4'd4, 4'd0, 2'b00, 2'b01, 1, 1);
    nTests++;
    if (out_sat !== 1'b0 || out_bins !== packBins())
      begin nFail++; $display("[TB] FAIL sat_next got sat=%b %h want sat=0 %h", out_sat, out_bins, packBins()); end
  endtask

  task automatic test_back_to_back();
    logic [NBIN*CNT_W-1:0] held;
    applyStimulus(1, 4'd12, 4'd13, 2'b01, 2'b11, 1, 0);
    held = packBins();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'd6, 4'd6, 2'b00, 2'b11, 1, 0);
      nTests++;
      if (obsReady !== 1'b0) begin nFail++; $display("[TB] FAIL hold_ready got %b want 0", obsReady); end
      nTests++;
      if (out_valid !== 1'b1 || out_bins !== held)
        begin nFail++; $display("[TB] FAIL hold_bins got v=%b %h want v=1 %h", out_valid, out_bins, held); end
    end
    applyStimulus(1, 4'd1, 4'd15, 2'b10, 2'b01, 1, 1);
    nTests++;
    if (obsReady !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_ready got %b want 1", obsReady); end
    nTests++;
    if (out_valid !== 1'b1 || out_bins[15:8] !== 8'd1 || out_bins !== packBins())
      begin nFail++; $display("[TB] FAIL b2b_bins got v=%b %h want v=1 %h", out_valid, out_bins, packBins()); end
    applyStimulus(0, 4'd0, 4'd0, 2'b00, 2'b00, 0, 1);
  endtask

  task automatic test_reset_mid_group();
    applyStimulus(1, 4'd4, 4'd4, 2'b00, 2'b11, 0, 1);
    applyStimulus(1, 4'd4, 4'd4, 2'b00, 2'b11, 0, 1);
    #2;
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 4'd9, 4'd4, 2'b00, 2'b01, 1, 1);
    nTests++;
    if (out_bins[9*8 +: 8] !== 8'd1 || out_bins[4*8 +: 8] !== 8'd0)
      begin nFail++; $display("[TB] FAIL rst_group got bin9=%h bin4=%h want 01 00", out_bins[9*8 +: 8], out_bins[4*8 +: 8]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] e0, e1;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      e0 = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom);
      e1 = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom);
      applyStimulus(($urandom_range(0, 9) < 8), e0, e1, 2'($urandom), 2'($urandom),
                    ($urandom_range(0, 99) < (narrow ? 2 : 15)), ($urandom_range(0, 3) != 0));
      nTests++;
      if (obsReady !== expReady) begin nFail++; $display("[TB] FAIL rnd_ready cycle %0d got %b want %b", i, obsReady, expReady); end
      nTests++;
      if (out_valid !== mValid || out_sat !== mSat || out_bins !== packBins())
        begin nFail++; $display("[TB] FAIL rnd_out cycle %0d got v=%b s=%b %h want v=%b s=%b %h",
                                i, out_valid, out_sat, out_bins, mValid, mSat, packBins()); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_exp = '0; in_sign = '0; in_en = '0; in_last = 0; out_ready = 0;
    modelReset();
    @(negedge clk);
    nTests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bins !== '0 || out_sat !== 1'b0)
      begin nFail++; $display("[TB] FAIL por_state got v=%b r=%b s=%b %h", out_valid, in_ready, out_sat, out_bins); end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_beat();
    test_groups();
    test_saturation();
    test_back_to_back();
    test_reset_mid_group();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
